// File: rtl/hex_entry_pkg.sv
// hex_entry_pkg: shared types and constants for the hex entry controller.
package hex_entry_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic {
        EDIT,
        PEND
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_COMMIT,
        ACT_INC,
        ACT_DEC,
        ACT_LEFT,
        ACT_RIGHT
    } act_t;

endpackage

// File: rtl/hex_entry_action_sel.sv
// hex_entry_action_sel: priority-encodes button pulses into one action per cycle.
//   state                      : controller state; pulses only act in EDIT
//   up_p/dn_p/lf_p/rt_p/ctr_p  : one-cycle press pulses
//   act                        : selected action (ctr > up > dn > lf > rt)
module hex_entry_action_sel
    import hex_entry_pkg::*;
(
    input  state_t state,
    input  logic   up_p,
    input  logic   dn_p,
    input  logic   lf_p,
    input  logic   rt_p,
    input  logic   ctr_p,
    output act_t   act
);

    always_comb begin
        act = (state != EDIT) ? ACT_NONE   :
              ctr_p           ? ACT_COMMIT :
              up_p            ? ACT_INC    :
              dn_p            ? ACT_DEC    :
              lf_p            ? ACT_LEFT   :
              rt_p            ? ACT_RIGHT  : ACT_NONE;
    end

endmodule

// File: rtl/hex_entry_ctrl.sv
// hex_entry_ctrl: button-driven hex value editor with valid/ready commit.
//   clk, rst_n           : clock, async active-low reset (sync release upstream)
//   up_p/dn_p            : increment/decrement digit under cursor (mod 16)
//   lf_p/rt_p            : move cursor toward MSD/LSD with wraparound
//   ctr_p                : commit value; locks edits until commit_ready
//   value, cursor        : live edit register and selected digit (0 = LSD)
//   commit_valid/_data   : pending commit and its held payload
//   commit_ready         : consumer accepts commit_data
//   busy                 : high while a commit is pending
//   blink_mask           : one-hot blank mask, active only with HEX_ENTRY_BLINK_EN
module hex_entry_ctrl
    import hex_entry_pkg::*;
#(
    parameter int                    DIGITS     = 8,
    parameter logic [4*DIGITS-1:0]   INIT_VALUE = '0,
    parameter int                    BLINK_BITS = 24,
    localparam int                   CW         = $clog2(DIGITS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     up_p,
    input  logic                     dn_p,
    input  logic                     lf_p,
    input  logic                     rt_p,
    input  logic                     ctr_p,
    output logic [4*DIGITS-1:0]      value,
    output logic [CW-1:0]            cursor,
    output logic                     commit_valid,
    output logic [4*DIGITS-1:0]      commit_data,
    input  logic                     commit_ready,
    output logic                     busy,
    output logic [DIGITS-1:0]        blink_mask
);

    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   value_q, value_d;
    logic [4*DIGITS-1:0]   commit_data_q, commit_data_d;
    logic [CW-1:0]         cursor_q, cursor_d;
    act_t                  act;

    hex_entry_action_sel u_sel (
        .state (state_q),
        .up_p  (up_p),
        .dn_p  (dn_p),
        .lf_p  (lf_p),
        .rt_p  (rt_p),
        .ctr_p (ctr_p),
        .act   (act)
    );

    always_comb begin
        state_d       = state_q;
        value_d       = value_q;
        cursor_d      = cursor_q;
        commit_data_d = commit_data_q;
        case (act)
            ACT_COMMIT: begin
                commit_data_d = value_q;
                state_d       = PEND;
            end
            ACT_INC:   value_d[cursor_q*NIBBLE +: NIBBLE] = value_q[cursor_q*NIBBLE +: NIBBLE] + 4'd1;
            ACT_DEC:   value_d[cursor_q*NIBBLE +: NIBBLE] = value_q[cursor_q*NIBBLE +: NIBBLE] - 4'd1;
            ACT_LEFT:  cursor_d = (cursor_q == LAST) ? '0 : cursor_q + CW'(1);
            ACT_RIGHT: cursor_d = (cursor_q == '0) ? LAST : cursor_q - CW'(1);
            default: ;
        endcase
        // Handshake completes only in PEND; any pulse this cycle was already masked.
        if (state_q == PEND && commit_ready)
            state_d = EDIT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= EDIT;
            value_q       <= INIT_VALUE;
            cursor_q      <= '0;
            commit_data_q <= INIT_VALUE;
        end else begin
            state_q       <= state_d;
            value_q       <= value_d;
            cursor_q      <= cursor_d;
            commit_data_q <= commit_data_d;
        end
    end

    // commit_valid is exactly "in PEND", so it drops with the async reset.
    assign value        = value_q;
    assign cursor       = cursor_q;
    assign commit_data  = commit_data_q;
    assign commit_valid = (state_q == PEND);
    assign busy         = (state_q == PEND);

`ifdef HEX_ENTRY_BLINK_EN
    logic [BLINK_BITS-1:0] cnt_q, cnt_d;

    // Edits restart the blink period so the touched digit is visible at once.
    always_comb begin
        cnt_d = (act == ACT_INC || act == ACT_DEC || act == ACT_LEFT || act == ACT_RIGHT)
              ? '0 : cnt_q + BLINK_BITS'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign blink_mask = (cnt_q[BLINK_BITS-1] && state_q == EDIT) ? (DIGITS'(1) << cursor_q) : '0;
`else
    // No blink counter in this build; the mask stays low.
    assign blink_mask = DIGITS'(0 * BLINK_BITS);
`endif

endmodule

// File: tb/tb_hex_entry_ctrl.sv
// tb_hex_entry_ctrl: directed plus random checks of hex_entry_ctrl (8 and 5 digits).
module tb_hex_entry_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic up_p = 1'b0, dn_p = 1'b0, lf_p = 1'b0, rt_p = 1'b0, ctr_p = 1'b0;
    logic commit_ready = 1'b0;

    logic [31:0] value8, cdata8;
    logic [2:0]  cursor8;
    logic        cvalid8, busy8;
    logic [7:0]  blink8;

    logic [19:0] value5, cdata5;
    logic [2:0]  cursor5;
    logic        cvalid5, busy5;
    logic [4:0]  blink5;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] m_val  [2];
    logic [63:0] m_cd   [2];
    int          m_cur  [2];
    bit          m_pend [2];
    int          ndig   [2] = '{8, 5};
    logic [63:0] init_v = 64'hFF;

    always #5 clk = ~clk;

    hex_entry_ctrl #(.DIGITS(8), .INIT_VALUE(32'h0000_00FF), .BLINK_BITS(24)) dut (
        .clk(clk), .rst_n(rst_n), .up_p(up_p), .dn_p(dn_p), .lf_p(lf_p), .rt_p(rt_p),
        .ctr_p(ctr_p), .value(value8), .cursor(cursor8), .commit_valid(cvalid8),
        .commit_data(cdata8), .commit_ready(commit_ready), .busy(busy8), .blink_mask(blink8)
    );

    hex_entry_ctrl #(.DIGITS(5), .INIT_VALUE(20'h000FF), .BLINK_BITS(24)) dut5 (
        .clk(clk), .rst_n(rst_n), .up_p(up_p), .dn_p(dn_p), .lf_p(lf_p), .rt_p(rt_p),
        .ctr_p(ctr_p), .value(value5), .cursor(cursor5), .commit_valid(cvalid5),
        .commit_data(cdata5), .commit_ready(commit_ready), .busy(busy5), .blink_mask(blink5)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_val[k] = init_v; m_cd[k] = init_v; m_cur[k] = 0; m_pend[k] = 0;
        end
    endtask

    // Digit-level reference: value treated as an integer of base-16 digits.
    task automatic model_step(input bit u, input bit d, input bit l, input bit r,
                              input bit c, input bit rdy);
        for (int k = 0; k < 2; k++) begin
            logic [63:0] dig;
            int sh;
            sh  = 4 * m_cur[k];
            dig = (m_val[k] >> sh) & 64'hF;
            if (m_pend[k]) begin
                if (rdy) m_pend[k] = 0;
            end else if (c) begin
                m_cd[k] = m_val[k]; m_pend[k] = 1;
            end else if (u) begin
                m_val[k] = m_val[k] - (dig << sh) + (((dig + 1) % 16) << sh);
            end else if (d) begin
                m_val[k] = m_val[k] - (dig << sh) + (((dig + 15) % 16) << sh);
            end else if (l) begin
                m_cur[k] = (m_cur[k] + 1) % ndig[k];
            end else if (r) begin
                m_cur[k] = (m_cur[k] + ndig[k] - 1) % ndig[k];
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".value8"},  {32'd0, value8},  m_val[0]);
        chk({tag, ".cursor8"}, {61'd0, cursor8}, 64'(m_cur[0]));
        chk({tag, ".valid8"},  {63'd0, cvalid8}, {63'd0, m_pend[0]});
        chk({tag, ".busy8"},   {63'd0, busy8},   {63'd0, m_pend[0]});
        chk({tag, ".cdata8"},  {32'd0, cdata8},  m_cd[0]);
        chk({tag, ".blink8"},  {56'd0, blink8},  64'd0);
        chk({tag, ".value5"},  {44'd0, value5},  m_val[1]);
        chk({tag, ".cursor5"}, {61'd0, cursor5}, 64'(m_cur[1]));
        chk({tag, ".valid5"},  {63'd0, cvalid5}, {63'd0, m_pend[1]});
        chk({tag, ".cdata5"},  {44'd0, cdata5},  m_cd[1]);
        chk({tag, ".blink5"},  {59'd0, blink5},  64'd0);
    endtask

    // Present inputs for one clock, update the model, then sample 1 time unit later.
    task automatic step(input string tag, input bit u, input bit d, input bit l,
                        input bit r, input bit c, input bit rdy);
        up_p = u; dn_p = d; lf_p = l; rt_p = r; ctr_p = c; commit_ready = rdy;
        @(posedge clk);
        model_step(u, d, l, r, c, rdy);
        #1;
        up_p = 0; dn_p = 0; lf_p = 0; rt_p = 0; ctr_p = 0; commit_ready = 0;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.value_const", {32'd0, value8}, 64'h0000_00FF);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("released");

        step("up1", 1, 0, 0, 0, 0, 0);
        chk("up1.const", {32'd0, value8}, 64'h0000_00F0);
        step("dn1", 0, 1, 0, 0, 0, 0);
        step("dn2", 0, 1, 0, 0, 0, 0);
        chk("dn2.const", {32'd0, value8}, 64'h0000_00FE);
        step("rt_wrap", 0, 0, 0, 1, 0, 0);
        chk("rt_wrap.c8", {61'd0, cursor8}, 64'd7);
        chk("rt_wrap.c5", {61'd0, cursor5}, 64'd4);
        step("up_msd", 1, 0, 0, 0, 0, 0);
        chk("up_msd.const8", {32'd0, value8}, 64'h1000_00FE);
        chk("up_msd.const5", {44'd0, value5}, 64'h1_00FE);
        step("lf_wrap", 0, 0, 1, 0, 0, 0);
        chk("lf_wrap.c8", {61'd0, cursor8}, 64'd0);
        for (int i = 0; i < 5; i++) step("lf_loop", 0, 0, 1, 0, 0, 0);
        chk("lf_loop.c5", {61'd0, cursor5}, 64'd0);
        chk("lf_loop.c8", {61'd0, cursor8}, 64'd5);
        step("up_dn_prio", 1, 1, 1, 1, 0, 0);
        step("lf_rt_prio", 0, 0, 1, 1, 0, 0);

        step("commit_prio", 1, 0, 1, 0, 1, 0);
        chk("commit_prio.data", {32'd0, cdata8}, {32'd0, value8});
        for (int i = 0; i < 10; i++) step("pend_hold", (i % 2) == 0, 0, 1, 0, 1, 0);
        step("handshake", 1, 1, 1, 1, 1, 1);
        chk("handshake.busy", {63'd0, busy8}, 64'd0);
        step("ready_idle", 0, 0, 0, 0, 0, 1);

        step("commit2", 0, 0, 0, 0, 1, 0);
        step("pend2", 1, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.valid8", {63'd0, cvalid8}, 64'd0);
        chk("async_rst.valid5", {63'd0, cvalid5}, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_all("in_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("after_reset");

        for (int i = 0; i < 400; i++) begin
            step("random", $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_entry_ctrl.md
Name: hex_entry_ctrl

Overview:
Consumes the one-cycle "just pressed" pulses from five per-button debouncers (up, down, left, right, centre) on the Nexys 4 and edits a DIGITS-wide hex value, one digit at a time, under a movable cursor. The centre press commits the value to the mining core (target/nonce-start load) through a valid/ready handshake. The value and cursor outputs drive the seven-segment display driver.

Parameters:
DIGITS, 8, number of hex digits edited; legal range 2..16, non-power-of-2 allowed.
INIT_VALUE, 0, reset value of the edit register (4*DIGITS bits).
BLINK_BITS, 24, width of the blink divider counter (used only with the optional feature).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
up_p  in  1  one-cycle press pulse: increment digit at cursor
dn_p  in  1  one-cycle press pulse: decrement digit at cursor
lf_p  in  1  one-cycle press pulse: move cursor toward the MSD
rt_p  in  1  one-cycle press pulse: move cursor toward the LSD
ctr_p  in  1  one-cycle press pulse: request commit
value  out  4*DIGITS  live edit register
cursor  out  CW=$clog2(DIGITS)  selected digit index; 0 = LSD
commit_valid  out  1  commit request pending
commit_data  out  4*DIGITS  last committed value, stable while commit_valid is high
commit_ready  in  1  consumer accepts commit_data
busy  out  1  high in PEND (edits locked)
blink_mask  out  DIGITS  one-hot blank mask for the display (optional feature)

Behaviour:
- Reset (async assert, sync release): value=INIT_VALUE, cursor=0, commit_valid=0, commit_data=INIT_VALUE, busy=0, blink_mask=0, state=EDIT, blink counter=0.
- States: EDIT, PEND.
- EDIT: at most one action per cycle. Priority when pulses coincide: ctr_p > up_p > dn_p > lf_p > rt_p; lower-priority pulses in that cycle are dropped, not queued.
  - up_p: digit[cursor] <= digit[cursor]+1 mod 16 (F->0). Other digits are unchanged.
  - dn_p: digit[cursor] <= digit[cursor]-1 mod 16 (0->F).
  - lf_p: cursor <= (cursor==DIGITS-1) ? 0 : cursor+1.
  - rt_p: cursor <= (cursor==0) ? DIGITS-1 : cursor-1.
  - ctr_p: commit_data <= value; commit_valid <= 1; go to PEND. Both take effect on the next cycle (1-cycle latency).
- PEND: busy=1. up/dn/lf/rt/ctr pulses are ignored. commit_valid and commit_data are held constant.
  - When commit_valid && commit_ready on a clock edge: commit_valid <= 0, return to EDIT. A pulse arriving in that same cycle is ignored.
- commit_ready is ignored while commit_valid=0. The block never drops commit_valid without a handshake, except on reset.
- Reset asserted mid-PEND: the commit is abandoned, commit_valid=0 immediately (async), and commit_data returns to INIT_VALUE.
- Digit slicing: digit i = value[4i+3:4i]. The cursor never holds an index >= DIGITS.

Optional Feature:
Macro HEX_ENTRY_BLINK_EN.
- Defined: a free-running BLINK_BITS counter runs in both states. blink_mask = (cnt[BLINK_BITS-1] && state==EDIT) ? one-hot(cursor) : 0. Any up/dn/lf/rt action clears the counter, so the selected digit is shown immediately.
- Undefined: no counter is built and blink_mask is tied to 0.

Decomposition:
- Package hex_entry_pkg: state enum {EDIT, PEND}; action-select encoding {ACT_NONE, ACT_COMMIT, ACT_INC, ACT_DEC, ACT_LEFT, ACT_RIGHT}; nibble width constant 4.
- One sub-module: hex_entry_action_sel, the combinational priority encoder mapping the five pulses plus state to an action code.
- Datapath and FSM stay in hex_entry_ctrl.

Test Plan:
- Reset with DIGITS=8, INIT_VALUE=32'h0000_00FF -> value=0x000000FF, cursor=0, commit_valid=0, blink_mask=0.
- From reset, up_p x1 -> value 0x000000F0 (F wraps to 0, no carry). Then dn_p x2 -> 0x000000FE.
- rt_p at cursor 0 -> cursor=7. up_p -> 0x100000FE. lf_p -> cursor=0. With DIGITS=5: lf_p x5 from 0 -> cursor back to 0.
- Same-cycle up_p+lf_p+ctr_p with value 0x12 -> commit only: commit_data=0x12, commit_valid=1 next cycle, value and cursor unchanged.
- In PEND with commit_ready=0 for 10 cycles plus up_p pulses -> value, commit_data and commit_valid stable. Raise commit_ready for 1 cycle -> commit_valid=0 and busy=0 next cycle.
- Assert rst_n=0 mid-PEND -> commit_valid drops within the same cycle (async). After release -> state EDIT, value=INIT_VALUE.
